seq_alu: RTL and testbench

- Parametrised multi-cycle successor to the accumulator-machine ALU; sits between ACC/BR (operands) and ACC/MR/DR (results).
- Single-cycle logic/arithmetic ops plus iterative shift-add multiply and restoring divide.
- Start/busy/done handshake lets the CU stall while a long op runs.

---
 rtl/seq_alu_pkg.sv | 45 ++++
 rtl/seq_alu_iter.sv | 70 +++++++
 rtl/seq_alu.sv | 243 ++++++++++++++++++++++++
 tb/tb_seq_alu.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: shared types for the sequential ALU.
//   op_e       - 4-bit opcode encoding
//   state_e    - control FSM states
//   FLAG_*     - bit positions inside the 4-bit flags bus {dz, carry, neg, zero}
//   is_iter_op - true for opcodes that run through the multi-cycle datapath
// Optional macro SEQ_ALU_SIGNED_EN makes MULS (11) and DIVS (12) iterative ops.
package seq_alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_XOR   = 4'd4,
    OP_NOT   = 4'd5,
    OP_SHL   = 4'd6,
    OP_SHR   = 4'd7,
    OP_MUL   = 4'd8,
    OP_DIV   = 4'd9,
    OP_PASSB = 4'd10,
    OP_MULS  = 4'd11,
    OP_DIVS  = 4'd12
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam int FLAG_ZERO  = 0;
  localparam int FLAG_NEG   = 1;
  localparam int FLAG_CARRY = 2;
  localparam int FLAG_DZ    = 3;

  // Opcodes that need WIDTH iterations of the shift-add / restoring datapath.
  function automatic logic is_iter_op(input logic [3:0] op);
`ifdef SEQ_ALU_SIGNED_EN
    return (op == OP_MUL) || (op == OP_DIV) || (op == OP_MULS) || (op == OP_DIVS);
`else
    return (op == OP_MUL) || (op == OP_DIV);
`endif
  endfunction

endpackage

// File: rtl/seq_alu_iter.sv
// seq_alu_iter: shared iterative datapath for unsigned multiply and divide.
//   clk, rst     - clock, synchronous active-high reset
//   load         - capture operands, clear the high half, counter <= WIDTH
//   step         - perform one shift-add (mode=0) or restoring (mode=1) step
//   mode         - 0: multiply, 1: divide (captured on load)
//   a, b         - unsigned operands (multiplier/dividend, multiplicand/divisor)
//   last         - the step taken in this cycle is the final one
//   result       - value the 2*WIDTH shift register takes after this cycle's
//                  step: multiply {hi, lo} product, divide {remainder, quotient}
module seq_alu_iter #(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic               mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               last,
  output logic [2*WIDTH-1:0] result
);

  logic [2*WIDTH-1:0] sr_q;
  logic [WIDTH-1:0]   b_q;
  logic               mode_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     trial;

  assign last = (cnt_q == CNT_W'(1));

  // Next shift-register value for one multiply or divide step.
  always_comb begin
    // Multiply: conditionally add B into the high half, then shift the
    // (WIDTH+1)-bit sum and the low half right by one.
    sum    = {1'b0, sr_q[2*WIDTH-1:WIDTH]} + (sr_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
    // Divide: shift {R, Q} left by one and try subtracting B from the new R.
    rem_sh = sr_q[2*WIDTH-1:WIDTH-1];
    trial  = rem_sh - {1'b0, b_q};
    if (mode_q == 1'b0) begin
      result = {sum, sr_q[WIDTH-1:1]};
    end else if (trial[WIDTH] == 1'b0) begin
      result = {trial[WIDTH-1:0], sr_q[WIDTH-2:0], 1'b1};
    end else begin
      result = {rem_sh[WIDTH-1:0], sr_q[WIDTH-2:0], 1'b0};
    end
  end

  // Operand capture, stepping and iteration counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q   <= {(2*WIDTH){1'b0}};
      b_q    <= {WIDTH{1'b0}};
      mode_q <= 1'b0;
      cnt_q  <= {CNT_W{1'b0}};
    end else if (load) begin
      sr_q   <= {{WIDTH{1'b0}}, a};
      b_q    <= b;
      mode_q <= mode;
      cnt_q  <= CNT_W'(WIDTH);
    end else if (step) begin
      sr_q  <= result;
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

endmodule

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle accumulator-machine ALU with start/busy/done handshake.
//   clk, rst   - clock, synchronous active-high reset
//   start, op  - op request and opcode, accepted whenever busy=0
//   acc_in     - operand A, br_in - operand B
//   busy       - high while a multiply/divide iterates
//   done       - one-cycle pulse when results are valid
//   acc_out    - main result / low product / quotient
//   mr_out     - high product half, dr_out - remainder
//   flags      - {dz, carry, neg, zero}
// Optional macro SEQ_ALU_SIGNED_EN adds MULS (11) and DIVS (12).
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] acc_in,
  input  logic [WIDTH-1:0] br_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] acc_out,
  output logic [WIDTH-1:0] mr_out,
  output logic [WIDTH-1:0] dr_out,
  output logic [3:0]       flags
);

  state_e             state_q, state_d;
  logic               accept;
  logic [3:0]         op_q;
  logic [WIDTH-1:0]   a_q;
  logic               b_zero_q;
  logic               iter_load, iter_step, iter_mode, iter_last;
  logic [WIDTH-1:0]   iter_a, iter_b;
  logic [2*WIDTH-1:0] iter_res;
  logic [WIDTH-1:0]   acc_d, mr_d, dr_d;
  logic [3:0]         flags_d;
  logic [WIDTH:0]     sum, diff;
  logic               carry_d, dz_d, legal_d;
`ifdef SEQ_ALU_SIGNED_EN
  logic               signed_op, a_neg_q, b_neg_q;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   q_fix, r_fix;
`endif

  // A request is taken in IDLE and in DONE, which gives back-to-back ops.
  assign accept    = start && (state_q != S_RUN);
  assign iter_mode = (op == OP_DIV) || (op == OP_DIVS);

`ifdef SEQ_ALU_SIGNED_EN
  // Signed ops iterate on magnitudes; the sign is restored on the final edge.
  assign signed_op = (op == OP_MULS) || (op == OP_DIVS);
  assign iter_a    = (signed_op && acc_in[WIDTH-1]) ? -acc_in : acc_in;
  assign iter_b    = (signed_op && br_in[WIDTH-1])  ? -br_in  : br_in;
`else
  assign iter_a    = acc_in;
  assign iter_b    = br_in;
`endif

  seq_alu_iter #(.WIDTH(WIDTH)) u_iter (
    .clk    (clk),
    .rst    (rst),
    .load   (iter_load),
    .step   (iter_step),
    .mode   (iter_mode),
    .a      (iter_a),
    .b      (iter_b),
    .last   (iter_last),
    .result (iter_res)
  );

  // Next-state and iterator control.
  always_comb begin
    state_d   = state_q;
    iter_load = 1'b0;
    iter_step = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          if (is_iter_op(op)) begin
            iter_load = 1'b1;
            state_d   = S_RUN;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        iter_step = 1'b1;
        if (iter_last) begin
          state_d = S_DONE;
        end else begin
          state_d = S_RUN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register with registered busy/done decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d == S_RUN);
      done    <= (state_d == S_DONE);
    end
  end

  // Per-op context needed when the iterative result is finalised.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= 4'd0;
      a_q      <= {WIDTH{1'b0}};
      b_zero_q <= 1'b0;
`ifdef SEQ_ALU_SIGNED_EN
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
`endif
    end else if (accept) begin
      op_q     <= op;
      a_q      <= acc_in;
      b_zero_q <= (br_in == {WIDTH{1'b0}});
`ifdef SEQ_ALU_SIGNED_EN
      a_neg_q  <= signed_op && acc_in[WIDTH-1];
      b_neg_q  <= signed_op && br_in[WIDTH-1];
`endif
    end
  end

  // Result and flag values to be written on the edge entering DONE.
  always_comb begin
    acc_d   = acc_out;
    mr_d    = mr_out;
    dr_d    = dr_out;
    carry_d = 1'b0;
    dz_d    = 1'b0;
    legal_d = 1'b1;
    sum     = {1'b0, acc_in} + {1'b0, br_in};
    diff    = {1'b0, acc_in} - {1'b0, br_in};
`ifdef SEQ_ALU_SIGNED_EN
    prod_fix = (a_neg_q ^ b_neg_q) ? -iter_res : iter_res;
    q_fix    = (a_neg_q ^ b_neg_q) ? -iter_res[WIDTH-1:0] : iter_res[WIDTH-1:0];
    r_fix    = a_neg_q ? -iter_res[2*WIDTH-1:WIDTH] : iter_res[2*WIDTH-1:WIDTH];
`endif
    if (state_q == S_RUN) begin
      case (op_q)
        OP_MUL: begin
          acc_d   = iter_res[WIDTH-1:0];
          mr_d    = iter_res[2*WIDTH-1:WIDTH];
          carry_d = |iter_res[2*WIDTH-1:WIDTH];
        end
        OP_DIV: begin
          if (b_zero_q) begin
            acc_d = {WIDTH{1'b1}};
            dr_d  = a_q;
            dz_d  = 1'b1;
          end else begin
            acc_d = iter_res[WIDTH-1:0];
            dr_d  = iter_res[2*WIDTH-1:WIDTH];
          end
        end
`ifdef SEQ_ALU_SIGNED_EN
        OP_MULS: begin
          acc_d   = prod_fix[WIDTH-1:0];
          mr_d    = prod_fix[2*WIDTH-1:WIDTH];
          carry_d = |prod_fix[2*WIDTH-1:WIDTH];
        end
        OP_DIVS: begin
          if (b_zero_q) begin
            acc_d = {WIDTH{1'b1}};
            dr_d  = a_q;
            dz_d  = 1'b1;
          end else begin
            acc_d   = q_fix;
            dr_d    = r_fix;
            // Only most-negative / -1 gives a positive quotient of magnitude 2^(WIDTH-1).
            carry_d = ~(a_neg_q ^ b_neg_q) & iter_res[WIDTH-1];
          end
        end
`endif
        default: legal_d = 1'b0;
      endcase
    end else begin
      case (op)
        OP_ADD: begin
          acc_d   = sum[WIDTH-1:0];
          carry_d = sum[WIDTH];
        end
        OP_SUB: begin
          acc_d   = diff[WIDTH-1:0];
          carry_d = diff[WIDTH];
        end
        OP_AND:   acc_d = acc_in & br_in;
        OP_OR:    acc_d = acc_in | br_in;
        OP_XOR:   acc_d = acc_in ^ br_in;
        OP_NOT:   acc_d = ~acc_in;
        OP_SHL: begin
          acc_d   = {acc_in[WIDTH-2:0], 1'b0};
          carry_d = acc_in[WIDTH-1];
        end
        OP_SHR: begin
          acc_d   = {1'b0, acc_in[WIDTH-1:1]};
          carry_d = acc_in[0];
        end
        OP_PASSB: acc_d = br_in;
        default:  legal_d = 1'b0;
      endcase
    end
    flags_d = 4'd0;
    if (legal_d) begin
      flags_d[FLAG_ZERO]  = (acc_d == {WIDTH{1'b0}});
      flags_d[FLAG_NEG]   = acc_d[WIDTH-1];
      flags_d[FLAG_CARRY] = carry_d;
      flags_d[FLAG_DZ]    = dz_d;
    end else begin
      flags_d = 4'd0;
    end
  end

  // Result registers: written only on the edge that enters DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_out <= {WIDTH{1'b0}};
      mr_out  <= {WIDTH{1'b0}};
      dr_out  <= {WIDTH{1'b0}};
      flags   <= 4'd0;
    end else if (state_d == S_DONE) begin
      acc_out <= acc_d;
      mr_out  <= mr_d;
      dr_out  <= dr_d;
      flags   <= flags_d;
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: randomized self-checking bench for seq_alu at WIDTH=32 and WIDTH=8.
// Expected values come from an arithmetic reference model of the opcode rules.
// Honors SEQ_ALU_SIGNED_EN for the signed opcodes.
module tb_seq_alu;

  logic        clk;
  logic        rst;
  logic        start, busy, done;
  logic [3:0]  op, flags;
  logic [31:0] a, b, acc_out, mr_out, dr_out;
  logic        start8, busy8, done8;
  logic [3:0]  op8, flags8;
  logic [7:0]  a8, b8, acc8, mr8, dr8;

  // Reference-model state for each instance.
  logic [63:0] e_acc, e_mr, e_dr;
  logic [3:0]  e_fl;
  logic [63:0] f_acc, f_mr, f_dr;
  logic [3:0]  f_fl;

  int checks;
  int errors;

  seq_alu #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .start(start), .op(op), .acc_in(a), .br_in(b),
    .busy(busy), .done(done), .acc_out(acc_out), .mr_out(mr_out),
    .dr_out(dr_out), .flags(flags)
  );

  seq_alu #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .op(op8), .acc_in(a8), .br_in(b8),
    .busy(busy8), .done(done8), .acc_out(acc8), .mr_out(mr8),
    .dr_out(dr8), .flags(flags8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit is_iter(input logic [3:0] o);
`ifdef SEQ_ALU_SIGNED_EN
    return (o == 4'd8) || (o == 4'd9) || (o == 4'd11) || (o == 4'd12);
`else
    return (o == 4'd8) || (o == 4'd9);
`endif
  endfunction

`ifdef SEQ_ALU_SIGNED_EN
  function automatic longint sext(input logic [63:0] v, input int w);
    if (v[w-1]) return longint'(v) - (longint'(1) << w);
    else        return longint'(v);
  endfunction
`endif

  // Reference model: applies one op to the architectural result state.
  task automatic model(input int w, input logic [3:0] o, input logic [63:0] xi, yi,
                       inout logic [63:0] acc, inout logic [63:0] mr,
                       inout logic [63:0] dr, output logic [3:0] fl);
    logic [63:0] mask, x, y, r;
    logic c, z, legal;
`ifdef SEQ_ALU_SIGNED_EN
    longint sa, sb, sp;
`endif
    mask = (64'd1 << w) - 64'd1;
    x = xi & mask; y = yi & mask;
    c = 1'b0; z = 1'b0; legal = 1'b1;
    case (o)
      4'd0: begin r = x + y; acc = r & mask; c = r[w]; end
      4'd1: begin r = x - y; acc = r & mask; c = (x < y); end
      4'd2: acc = x & y;
      4'd3: acc = x | y;
      4'd4: acc = x ^ y;
      4'd5: acc = ~x & mask;
      4'd6: begin acc = (x << 1) & mask; c = x[w-1]; end
      4'd7: begin acc = x >> 1; c = x[0]; end
      4'd8: begin r = x * y; acc = r & mask; mr = (r >> w) & mask; c = (mr != 64'd0); end
      4'd9: begin
        if (y == 64'd0) begin acc = mask; dr = x; z = 1'b1; end
        else begin acc = x / y; dr = x % y; end
      end
      4'd10: acc = y;
`ifdef SEQ_ALU_SIGNED_EN
      4'd11: begin
        sa = sext(x, w); sb = sext(y, w); sp = sa * sb;
        acc = sp & mask; mr = (sp >>> w) & mask; c = (mr != 64'd0);
      end
      4'd12: begin
        sa = sext(x, w); sb = sext(y, w);
        if (y == 64'd0) begin acc = mask; dr = x; z = 1'b1; end
        else if (sa == -(longint'(1) << (w - 1)) && sb == -1) begin
          acc = x; dr = 64'd0; c = 1'b1;
        end else begin
          acc = (sa / sb) & mask; dr = (sa % sb) & mask;
        end
      end
`endif
      default: legal = 1'b0;
    endcase
    if (legal) fl = {z, c, acc[w-1], (acc == 64'd0)};
    else       fl = 4'd0;
  endtask

  // Issue one op on the 32-bit instance; returns cycles to done and busy count.
  task automatic do_op32(input logic [3:0] o, input logic [31:0] x, y,
                         output int lat, output int bc);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = $urandom; b = $urandom;
    model(32, o, {32'd0, x}, {32'd0, y}, e_acc, e_mr, e_dr, e_fl);
    lat = 1; bc = 0;
    while (done !== 1'b1 && lat < 100) begin
      if (busy === 1'b1) bc++;
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL timeout32 op=%0d done=%b required 1 within 100 cycles", o, done);
    end
  endtask

  task automatic do_op8(input logic [3:0] o, input logic [7:0] x, y,
                        output int lat, output int bc);
    op8 = o; a8 = x; b8 = y; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom);
    model(8, o, {56'd0, x}, {56'd0, y}, f_acc, f_mr, f_dr, f_fl);
    lat = 1; bc = 0;
    while (done8 !== 1'b1 && lat < 100) begin
      if (busy8 === 1'b1) bc++;
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (done8 !== 1'b1) begin
      errors++;
      $display("FAIL timeout8 op=%0d done=%b required 1 within 100 cycles", o, done8);
    end
  endtask

  task automatic test_reset;
    int lat, bc, n;
    rst = 1'b1; start = 1'b0; start8 = 1'b0;
    op = 4'd0; a = 32'd0; b = 32'd0; op8 = 4'd0; a8 = 8'd0; b8 = 8'd0;
    repeat (3) @(posedge clk);
    #1; rst = 1'b0;
    e_acc = 64'd0; e_mr = 64'd0; e_dr = 64'd0; e_fl = 4'd0;
    f_acc = 64'd0; f_mr = 64'd0; f_dr = 64'd0; f_fl = 4'd0;
    checks++;
    if ({busy, done, acc_out, mr_out, dr_out, flags} !== 102'd0 ||
        {busy8, done8, acc8, mr8, dr8, flags8} !== 30'd0) begin
      errors++;
      $display("FAIL reset_state busy=%b done=%b acc=%h mr=%h dr=%h fl=%b required all 0",
               busy, done, acc_out, mr_out, dr_out, flags);
    end
    // Leave non-zero results, then abort a second multiply mid-run.
    do_op32(4'd8, 32'h1234_5678, 32'h9abc_def0, lat, bc);
    op = 4'd8; a = 32'hdead_beef; b = 32'h0000_0101; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_mid_run busy=%b required 1", busy);
    end
    rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    e_acc = 64'd0; e_mr = 64'd0; e_dr = 64'd0; e_fl = 4'd0;
    checks++;
    if ({busy, done, acc_out, mr_out, dr_out, flags} !== 102'd0) begin
      errors++;
      $display("FAIL reset_abort busy=%b done=%b acc=%h mr=%h dr=%h fl=%b required all 0",
               busy, done, acc_out, mr_out, dr_out, flags);
    end
    n = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done !== 1'b0) n++;
    end
    checks++;
    if (n != 0) begin
      errors++;
      $display("FAIL no_done_after_abort done_cycles=%0d required 0", n);
    end
  endtask

  task automatic test_add;
    int lat, bc;
    do_op32(4'd0, 32'hffff_ffff, 32'd1, lat, bc);
    checks++;
    if (lat != 1 || acc_out !== 32'd0 || flags !== 4'b0101) begin
      errors++;
      $display("FAIL add_wrap lat=%0d acc=%h fl=%b required lat=1 acc=0 fl=0101", lat, acc_out, flags);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL add_done_pulse done=%b required 0", done);
    end
  endtask

  task automatic test_mul;
    int lat, bc;
    do_op32(4'd8, 32'h0001_0000, 32'h0001_0000, lat, bc);
    checks++;
    if (lat != 33 || bc != 32) begin
      errors++;
      $display("FAIL mul_latency lat=%0d busy_cycles=%0d required 33 and 32", lat, bc);
    end
    checks++;
    if (acc_out !== 32'd0 || mr_out !== 32'd1 || flags !== 4'b0101 ||
        dr_out !== e_dr[31:0]) begin
      errors++;
      $display("FAIL mul_result acc=%h mr=%h dr=%h fl=%b required acc=0 mr=1 dr=%h fl=0101",
               acc_out, mr_out, dr_out, flags, e_dr[31:0]);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mul_done_pulse done=%b busy=%b required 0 0", done, busy);
    end
  endtask

  task automatic test_div;
    int lat, bc;
    do_op32(4'd9, 32'd100, 32'd7, lat, bc);
    checks++;
    if (lat != 33 || acc_out !== 32'd14 || dr_out !== 32'd2 || flags !== 4'b0000 ||
        mr_out !== e_mr[31:0]) begin
      errors++;
      $display("FAIL div_100_7 lat=%0d acc=%0d dr=%0d mr=%h fl=%b required 33 14 2 %h 0000",
               lat, acc_out, dr_out, mr_out, flags, e_mr[31:0]);
    end
    do_op32(4'd9, 32'd5, 32'd0, lat, bc);
    checks++;
    if (lat != 33 || acc_out !== 32'hffff_ffff || dr_out !== 32'd5 || flags !== 4'b1010) begin
      errors++;
      $display("FAIL div_by_zero lat=%0d acc=%h dr=%0d fl=%b required 33 ffffffff 5 1010",
               lat, acc_out, dr_out, flags);
    end
  endtask

  task automatic test_handshake;
    int lat, bc;
    op = 4'd8; a = 32'd7; b = 32'd9; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    model(32, 4'd8, 64'd7, 64'd9, e_acc, e_mr, e_dr, e_fl);
    lat = 1;
    repeat (5) begin @(posedge clk); #1; lat++; end
    op = 4'd0; a = 32'd100; b = 32'd200; start = 1'b1;
    @(posedge clk); #1; start = 1'b0; lat++;
    while (done !== 1'b1 && lat < 100) begin @(posedge clk); #1; lat++; end
    checks++;
    if (lat != 33 || acc_out !== 32'd63 || mr_out !== 32'd0 || flags !== e_fl) begin
      errors++;
      $display("FAIL ignore_start_busy lat=%0d acc=%0d mr=%h fl=%b required 33 63 0 %b",
               lat, acc_out, mr_out, flags, e_fl);
    end
    // Back-to-back: new request issued in the DONE cycle.
    do_op32(4'd1, 32'd3, 32'd5, lat, bc);
    checks++;
    if (lat != 1 || acc_out !== 32'hffff_fffe || flags !== 4'b0110 ||
        mr_out !== e_mr[31:0] || dr_out !== e_dr[31:0]) begin
      errors++;
      $display("FAIL back_to_back_sub lat=%0d acc=%h fl=%b mr=%h dr=%h required 1 fffffffe 0110 %h %h",
               lat, acc_out, flags, mr_out, dr_out, e_mr[31:0], e_dr[31:0]);
    end
  endtask

  task automatic test_random32;
    int lat, bc;
    logic [3:0] o;
    logic [31:0] x, y;
    for (int i = 0; i < 40; i++) begin
      o = 4'($urandom_range(0, 15));
      x = (i % 7 == 3) ? 32'h8000_0000 : 32'($urandom);
      y = ($urandom_range(0, 4) == 0) ? 32'd0 : ((i % 7 == 3) ? 32'hffff_ffff : 32'($urandom));
      do_op32(o, x, y, lat, bc);
      checks++;
      if (lat != (is_iter(o) ? 33 : 1)) begin
        errors++;
        $display("FAIL rand32_latency op=%0d lat=%0d required %0d", o, lat, is_iter(o) ? 33 : 1);
      end
      checks++;
      if (acc_out !== e_acc[31:0] || mr_out !== e_mr[31:0] || dr_out !== e_dr[31:0] ||
          flags !== e_fl) begin
        errors++;
        $display("FAIL rand32_result op=%0d a=%h b=%h got acc=%h mr=%h dr=%h fl=%b required acc=%h mr=%h dr=%h fl=%b",
                 o, x, y, acc_out, mr_out, dr_out, flags, e_acc[31:0], e_mr[31:0], e_dr[31:0], e_fl);
      end
    end
  endtask

  task automatic test_width8;
    int lat, bc;
    logic [3:0] o;
    logic [7:0] x, y;
    do_op8(4'd8, 8'hff, 8'hff, lat, bc);
    checks++;
    if (lat != 9 || bc != 8 || {mr8, acc8} !== 16'hfe01) begin
      errors++;
      $display("FAIL w8_mul lat=%0d busy_cycles=%0d prod=%h required 9 8 fe01", lat, bc, {mr8, acc8});
    end
    do_op8(4'd7, 8'h81, 8'h00, lat, bc);
    checks++;
    if (lat != 1 || acc8 !== 8'h40 || flags8 !== 4'b0100) begin
      errors++;
      $display("FAIL w8_shr lat=%0d acc=%h fl=%b required 1 40 0100", lat, acc8, flags8);
    end
    for (int i = 0; i < 25; i++) begin
      o = 4'($urandom_range(0, 15));
      x = (i % 5 == 2) ? 8'h80 : 8'($urandom);
      y = ($urandom_range(0, 4) == 0) ? 8'd0 : ((i % 5 == 2) ? 8'hff : 8'($urandom));
      do_op8(o, x, y, lat, bc);
      checks++;
      if (lat != (is_iter(o) ? 9 : 1) || acc8 !== f_acc[7:0] || mr8 !== f_mr[7:0] ||
          dr8 !== f_dr[7:0] || flags8 !== f_fl) begin
        errors++;
        $display("FAIL rand8 op=%0d a=%h b=%h lat=%0d got acc=%h mr=%h dr=%h fl=%b required acc=%h mr=%h dr=%h fl=%b",
                 o, x, y, lat, acc8, mr8, dr8, flags8, f_acc[7:0], f_mr[7:0], f_dr[7:0], f_fl);
      end
    end
  endtask

`ifdef SEQ_ALU_SIGNED_EN
  task automatic test_signed;
    int lat, bc;
    do_op32(4'd12, 32'hffff_fff9, 32'd2, lat, bc);
    checks++;
    if (lat != 33 || acc_out !== 32'hffff_fffd || dr_out !== 32'hffff_ffff) begin
      errors++;
      $display("FAIL divs_m7_2 lat=%0d acc=%h dr=%h required 33 fffffffd ffffffff", lat, acc_out, dr_out);
    end
    do_op32(4'd11, 32'hffff_fffd, 32'd4, lat, bc);
    checks++;
    if (lat != 33 || acc_out !== 32'hffff_fff4 || mr_out !== 32'hffff_ffff) begin
      errors++;
      $display("FAIL muls_m3_4 lat=%0d acc=%h mr=%h required 33 fffffff4 ffffffff", lat, acc_out, mr_out);
    end
    do_op32(4'd12, 32'h8000_0000, 32'hffff_ffff, lat, bc);
    checks++;
    if (acc_out !== 32'h8000_0000 || flags !== e_fl || flags[2] !== 1'b1) begin
      errors++;
      $display("FAIL divs_overflow acc=%h fl=%b required 80000000 %b", acc_out, flags, e_fl);
    end
  endtask
`else
  task automatic test_illegal;
    int lat, bc;
    do_op32(4'd4, 32'h0f0f_1234, 32'h00ff_4321, lat, bc);
    do_op32(4'd11, 32'h1111_1111, 32'h2222_2222, lat, bc);
    checks++;
    if (lat != 1 || acc_out !== e_acc[31:0] || mr_out !== e_mr[31:0] ||
        dr_out !== e_dr[31:0] || flags !== 4'd0) begin
      errors++;
      $display("FAIL illegal_op11 lat=%0d acc=%h mr=%h dr=%h fl=%b required 1 %h %h %h 0000",
               lat, acc_out, mr_out, dr_out, flags, e_acc[31:0], e_mr[31:0], e_dr[31:0]);
    end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_add();
    test_mul();
    test_div();
    test_handshake();
`ifdef SEQ_ALU_SIGNED_EN
    test_signed();
`else
    test_illegal();
`endif
    test_random32();
    test_width8();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
